// File: rtl/i2c_slave.sv
//============================================================================
// Module   : i2c_slave
// Purpose  : I2C target (responder) with a fixed 7-bit address. SCL and SDA
//            are oversampled on clk. The block detects START, repeated START
//            and STOP. Bytes written by the master appear on rx_data, and
//            bytes read by the master are taken from tx_data.
// Ports    : clk      - system clock (at least 8x the SCL frequency)
//            rst      - asynchronous active-high reset
//            SCL      - bus clock input (this block never stretches it)
//            SDA      - open-drain data line (driven only to 0, else z)
//            rx_data  - last byte received in a write transfer
//            rx_valid - one-clk pulse when rx_data is updated
//            tx_data  - byte returned in a read transfer
//            tx_taken - one-clk pulse when tx_data is captured
//            busy     - high from address match until STOP or START
// Revision : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h2A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_taken,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_RX       = 3'd3,
    S_RX_ACK   = 3'd4,
    S_TX       = 3'd5,
    S_TX_ACK   = 3'd6,
    S_IGNORE   = 3'd7
  } state_t;

  // Two synchronizer stages plus one delay stage for edge detection.
  // These flops reset to 1 because an idle bus reads high.
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= SCL;    scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= SDA;    sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  assign start_det =  scl_s2 &  sda_d & ~sda_s2;
  assign stop_det  =  scl_s2 & ~sda_d &  sda_s2;

  // Registered state and next-state values.
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;     // address/rx shift in, tx shift out
  logic       rw_q, rw_d;
  logic       phase_q, phase_d;     // ACK sub-phase / master-ACK-seen flag
  logic       drive_q, drive_d;     // 1 = pull SDA low
  logic [7:0] rx_data_d;
  logic       rx_valid_d, tx_taken_d, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      shift_q  <= 8'h00;
      rw_q     <= 1'b0;
      phase_q  <= 1'b0;
      drive_q  <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_taken <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      rw_q     <= rw_d;
      phase_q  <= phase_d;
      drive_q  <= drive_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
      tx_taken <= tx_taken_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    drive_d    = drive_q;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    tx_taken_d = 1'b0;
    busy_d     = busy;

    if (start_det) begin
      // START and repeated START both restart address decoding.
      state_d = S_ADDR;
      cnt_d   = 3'd0;
      drive_d = 1'b0;
      busy_d  = 1'b0;
      phase_d = 1'b0;
    end else if (stop_det) begin
      state_d = S_IDLE;
      drive_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s2};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              // The first seven bits are in shift_q, and the R/W bit is on the wire.
              if (shift_q[6:0] == ADDR) begin
                state_d = S_ADDR_ACK;
                rw_d    = sda_s2;
                phase_d = 1'b0;
                busy_d  = 1'b1;
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end

        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              drive_d = 1'b1;
              phase_d = 1'b1;
            end else if (rw_q) begin
              shift_d    = tx_data;
              tx_taken_d = 1'b1;
              drive_d    = ~tx_data[7];
              cnt_d      = 3'd0;
              state_d    = S_TX;
            end else begin
              drive_d = 1'b0;
              cnt_d   = 3'd0;
              state_d = S_RX;
            end
          end
        end

        S_RX: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s2};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = {shift_q[6:0], sda_s2};
              rx_valid_d = 1'b1;
              phase_d    = 1'b0;
              state_d    = S_RX_ACK;
            end
          end
        end

        S_RX_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              drive_d = 1'b1;
              phase_d = 1'b1;
            end else begin
              drive_d = 1'b0;
              cnt_d   = 3'd0;
              state_d = S_RX;
            end
          end
        end

        S_TX: begin
          // Bit 7 is presented on entry. The count tracks how many later bits have been shifted out.
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              drive_d = 1'b0;
              cnt_d   = 3'd0;
              phase_d = 1'b0;
              state_d = S_TX_ACK;
            end else begin
              drive_d = ~shift_q[6];
              shift_d = {shift_q[6:0], 1'b0};
              cnt_d   = cnt_q + 3'd1;
            end
          end
        end

        S_TX_ACK: begin
          if (scl_rise && !phase_q) begin
            if (sda_s2) state_d = S_IGNORE;  // master NACK
            else        phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            shift_d    = tx_data;
            tx_taken_d = 1'b1;
            drive_d    = ~tx_data[7];
            cnt_d      = 3'd0;
            state_d    = S_TX;
          end
        end

        default: ;  // IDLE and IGNORE only wait for START or STOP
      endcase
    end
  end

  // The drive flop resets asynchronously, so reset releases the bus at once.
  assign SDA = drive_q ? 1'b0 : 1'bz;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
//============================================================================
// Module   : tb_i2c_slave
// Purpose  : Directed self-checking bench for i2c_slave. The bench acts as
//            the I2C master on a pulled-up SDA line.
// Revision : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_slave;

  localparam int Q = 50;  // quarter SCL period, 5 clk

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'hA5;
  logic [7:0] rx_data;
  logic       rx_valid, tx_taken, busy;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave dut (
    .clk      (clk),
    .rst      (rst),
    .SCL      (scl),
    .SDA      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_taken (tx_taken),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int slave_low_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_cnt++;
    if (tx_taken === 1'b1) tx_cnt++;
    if (!m_low && sda === 1'b0) slave_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_x(input logic b, output logic r);
    m_low = ~b; #Q;
    scl = 1'b1; #Q;
    r = sda;    #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic start_c();
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic stop_c();
    m_low = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b0; #(4*Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(d[i], r);
    bit_x(1'b1, ack);
  endtask

  task automatic read8(output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         rc0, tc0, lc0;

    // Reset state
    #23;
    check("rst_sda", sda, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_taken", tx_taken, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    #40;

    // Write 0x2A/W, 0x55, STOP
    rc0 = rx_cnt;
    start_c();
    write_byte(8'h54, ack);
    check("w_addr_ack", ack, 1'b0);
    check("w_busy", busy, 1'b1);
    write_byte(8'h55, ack);
    check("w_data_ack", ack, 1'b0);
    check("w_rx_data", rx_data, 8'h55);
    check("w_rx_valid_cnt", rx_cnt - rc0, 1);
    stop_c();
    check("w_busy_after_stop", busy, 1'b0);

    // Wrong address 0x2B: the slave stays silent
    rc0 = rx_cnt;
    lc0 = slave_low_cnt;
    start_c();
    write_byte(8'h56, ack);
    check("na_addr_nack", ack, 1'b1);
    write_byte(8'h12, ack);
    check("na_data_nack", ack, 1'b1);
    check("na_busy", busy, 1'b0);
    stop_c();
    check("na_never_driven", slave_low_cnt - lc0, 0);
    check("na_no_rx_valid", rx_cnt - rc0, 0);
    check("na_rx_data_kept", rx_data, 8'h55);

    // Read 0x2A/R with 0xA5, then master NACK
    tx_data = 8'hA5;
    tc0 = tx_cnt;
    start_c();
    write_byte(8'h55, ack);
    check("r1_addr_ack", ack, 1'b0);
    read8(d);
    check("r1_byte", d, 8'hA5);
    bit_x(1'b1, r);
    check("r1_released_after_nack", sda, 1'b1);
    check("r1_tx_taken_cnt", tx_cnt - tc0, 1);
    stop_c();
    check("r1_busy_after_stop", busy, 1'b0);

    // Two-byte read: ACK then NACK, with tx_data changed between bytes
    tx_data = 8'hA5;
    tc0 = tx_cnt;
    start_c();
    write_byte(8'h55, ack);
    check("r2_addr_ack", ack, 1'b0);
    read8(d);
    check("r2_byte0", d, 8'hA5);
    tx_data = 8'h3C;
    bit_x(1'b0, r);
    read8(d);
    check("r2_byte1", d, 8'h3C);
    bit_x(1'b1, r);
    check("r2_tx_taken_cnt", tx_cnt - tc0, 2);
    stop_c();

    // Write 0x11, repeated START, then read
    tx_data = 8'h96;
    start_c();
    write_byte(8'h54, ack);
    check("rs_w_addr_ack", ack, 1'b0);
    write_byte(8'h11, ack);
    check("rs_w_data_ack", ack, 1'b0);
    start_c();
    write_byte(8'h55, ack);
    check("rs_r_addr_ack", ack, 1'b0);
    read8(d);
    check("rs_r_byte", d, 8'h96);
    bit_x(1'b1, r);
    stop_c();
    check("rs_rx_data", rx_data, 8'h11);

    // Reset while the slave drives the address ACK
    start_c();
    for (int i = 7; i >= 0; i--) bit_x(((8'h54 >> i) & 8'h01) != 8'h00, r);
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    check("rr_ack_driven", sda, 1'b0);
    rst = 1'b1;
    #1;
    check("rr_sda_released", sda, 1'b1);
    check("rr_busy", busy, 1'b0);
    check("rr_rx_data", rx_data, 8'h00);
    check("rr_rx_valid", rx_valid, 1'b0);
    #20;
    scl = 1'b0; #Q;
    rst = 1'b0; #Q;
    rc0 = rx_cnt;
    start_c();
    write_byte(8'h54, ack);
    check("rr_next_addr_ack", ack, 1'b0);
    write_byte(8'h77, ack);
    check("rr_next_data_ack", ack, 1'b0);
    stop_c();
    check("rr_next_rx_data", rx_data, 8'h77);
    check("rr_next_rx_valid_cnt", rx_cnt - rc0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_slave.md
# i2c_slave

I2C target (responder) for the bus driven by the team's `mod_I2C` master. It oversamples `SCL`/`SDA` on the system clock and detects START, repeated START and STOP. It matches a fixed 7-bit address, accepts write bytes onto a parallel output, and serves read bytes from a parallel input. It sits on the same `SDA`/`SCL` wires as the master and serves as the bench responder and as an on-chip register target.

## Interface
- `ADDR`, 7'h2A, own 7-bit bus address.
- `clk`  input  1  system clock; must be ≥ 8× SCL frequency.
- `rst`  input  1  asynchronous, active-high reset.
- `SCL`  input  1  bus clock, slave never stretches.
- `SDA`  inout  1  open-drain data; driven only to 0, otherwise `1'bz`.
- `rx_data`  output  8  last byte received in a write transfer.
- `rx_valid`  output  1  one-clk pulse, `rx_data` updated.
- `tx_data`  input  8  byte to return in a read transfer.
- `tx_taken`  output  1  one-clk pulse, `tx_data` captured; next byte may be presented.
- `busy`  output  1  high from address match until STOP or START.

## Operation
- Input conditioning: 2-flop synchronizers on `SCL` and `SDA` (undriven bus reads as 1), plus one delay flop each for edge detection.
- START: synced SDA 1→0 while synced SCL = 1. STOP: synced SDA 0→1 while SCL = 1. Both are recognised in any state and take priority over bit events in the same cycle.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE.
- IDLE: SDA released. START → ADDR with bit counter = 0.
- ADDR: shift 8 bits MSB-first on SCL rising edges; the 8th bit is R/W.
  - Address match → ADDR_ACK.
  - Mismatch → IGNORE; SDA is never driven.
- ADDR_ACK: drive SDA=0 on the next SCL falling edge and set `busy`.
  - R/W=0: release SDA on the following falling edge → RX.
  - R/W=1: on the following falling edge, capture `tx_data`, pulse `tx_taken`, drive bit 7 → TX.
- RX: shift 8 bits on rising edges. After the 8th, update `rx_data` and pulse `rx_valid` → RX_ACK. Every byte is ACKed; there is no NACK path.
- RX_ACK: drive 0 on the next falling edge, release on the following falling edge → RX.
- TX: on each falling edge, present the next bit (0 → drive low, 1 → release). After bit 0 has been held, release on the next falling edge → TX_ACK.
- TX_ACK: sample master ACK on the rising edge.
  - 0: capture new `tx_data` on the next falling edge, pulse `tx_taken`, drive its bit 7 → TX.
  - 1: NACK → IGNORE.
- IGNORE: SDA released; wait for START (→ ADDR) or STOP (→ IDLE).
- STOP anywhere → IDLE, SDA released, `busy`=0.
- Repeated START anywhere → ADDR, counter cleared, SDA released, `busy`=0.

## Timing
- Reset values: SDA released (`z`), `rx_data`=8'h00, `rx_valid`=0, `tx_taken`=0, `busy`=0, state IDLE. Reset mid-transfer releases SDA immediately (asynchronously).
- Pin-to-event latency: 3 clk (2 synchronizer stages + 1 edge flop).
- SDA output changes 1 clk after a detected SCL falling edge, i.e. 4 clk after the pin edge. This stays within the SCL low phase given the 8× clock ratio.
- `rx_valid` fires 1 clk after the detected 8th rising edge, coincident with `rx_data` update; it is 1 clk wide.
- `tx_taken` is 1 clk wide, in the same cycle `tx_data` is registered.
- The slave never drives SDA while SCL is high, except to hold a value across that high phase; it therefore cannot create START/STOP.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.

## Test plan
- Write 0x2A/W, data 0x55, STOP → ACK low on 9th clock after the address and after the data; `rx_data`=0x55 with one `rx_valid` pulse; `busy` returns 0 after STOP.
- Address 0x2B/W, data byte → SDA never driven (stays `z`/1); no `rx_valid`; state IGNORE until STOP.
- Read 0x2A/R, `tx_data`=0xA5, master NACK, STOP → SDA carries 1,0,1,0,0,1,0,1; one `tx_taken` pulse; SDA released after NACK.
- Two-byte read, `tx_data` changed to 0x3C after the first `tx_taken`, master ACK then NACK → bytes 0xA5 then 0x3C; exactly two `tx_taken` pulses.
- Write 0x2A/W, 0x11, repeated START, 0x2A/R → `rx_data`=0x11; the second address is ACKed; read proceeds with the current `tx_data`.
- Assert `rst` while the slave drives the ACK low → SDA goes `z` within the same cycle; all outputs return to reset values; the next START is decoded normally.
